// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared AXI-Stream helpers for the width converters and FIFO wrappers.
//   - cnt_width(n) : width of a counter holding 0..n-1, never below 1 bit.
//   - lane_lo(k,w) : LSB index of lane k in a packed word of w-bit lanes.
//                    Lanes are little-endian: lane 0 occupies the LSBs.
//   - keep_mask(c) : contiguous ones in bits 0..c; callers cast to lane count.
// -----------------------------------------------------------------------------
package axis_pkg;

  // Widest keep mask keep_mask() can produce.
  localparam int unsigned AXIS_MAX_LANES = 32;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  function automatic logic [AXIS_MAX_LANES-1:0] keep_mask(input int unsigned c);
    logic [AXIS_MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < AXIS_MAX_LANES; i++) begin
      if (i <= c) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Valid/ready holding register for a stream output. Payload is opaque (W bits).
//   clk      in   clock
//   rstn     in   synchronous active-low reset; clears valid and payload
//   i_load   in   capture i_data this cycle; only assert while o_ready is high
//   i_data   in   payload to capture
//   i_tready in   downstream ready
//   o_tvalid out  downstream valid
//   o_ready  out  register can take a new payload this cycle (!valid | ready)
//   o_data   out  held payload, stable while valid and not ready
// -----------------------------------------------------------------------------
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_tready,
  output logic         o_tvalid,
  output logic         o_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready  = !r_valid | i_tready;
  assign o_tvalid = r_valid;
  assign o_data   = r_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      // A load on the same cycle as a drain keeps valid high (back-to-back).
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid & i_tready) begin
      // Payload is left stale; only valid drops.
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// -----------------------------------------------------------------------------
// axis_upsizer
// Packs RATIO narrow AXI-Stream beats into one wide word. An input tlast closes
// a partial word early; o_tkeep marks the populated lanes (contiguous from 0).
//   clk      in   clock
//   rstn     in   synchronous active-low reset; drops partial and held words
//   i_tvalid in   narrow beat valid
//   o_tready out  narrow beat ready (depends only on output state and i_tready)
//   i_tdata  in   narrow beat data, DLEN bits
//   i_tlast  in   narrow beat closes the packet
//   o_tvalid out  wide word valid
//   i_tready in   wide word ready
//   o_tdata  out  wide word, lane k at [k*DLEN +: DLEN]
//   o_tkeep  out  lane-valid mask
//   o_tlast  out  wide word closes the packet
// -----------------------------------------------------------------------------
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int DLEN  = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  input  logic [DLEN-1:0]       i_tdata,
  input  logic                  i_tlast,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [DLEN*RATIO-1:0] o_tdata,
  output logic [RATIO-1:0]      o_tkeep,
  output logic                  o_tlast
);

  localparam int CLEN = cnt_width(RATIO);
  localparam int WLEN = DLEN * RATIO;
  localparam int OLEN = WLEN + RATIO + 1;

  // Assembly register
  logic [WLEN-1:0]  r_data;
  logic [RATIO-1:0] r_keep;
  logic [CLEN-1:0]  r_cnt;

  logic             w_ready;
  logic             w_in_acc;
  logic             w_last_lane;
  logic             w_done;
  logic [RATIO-1:0] w_lane_sel;
  logic [RATIO-1:0] w_keep_out;
  logic [WLEN-1:0]  w_merged;
  logic [OLEN-1:0]  w_out;

  assign o_tready    = w_ready;
  assign w_in_acc    = i_tvalid & w_ready;
  assign w_last_lane = (r_cnt == CLEN'(RATIO - 1));
  assign w_done      = w_in_acc & (w_last_lane | i_tlast);

  // Current beat overlays lane r_cnt. Lanes above r_cnt are still zero because
  // the assembly register is cleared on every completion.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign w_lane_sel[gi] = (r_cnt == CLEN'(gi));
      assign w_merged[lane_lo(gi, DLEN) +: DLEN] =
        w_lane_sel[gi] ? i_tdata : r_data[lane_lo(gi, DLEN) +: DLEN];
    end
  endgenerate

  assign w_keep_out = r_keep | w_lane_sel;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data <= '0;
      r_keep <= '0;
      r_cnt  <= '0;
    end else if (w_done) begin
      r_data <= '0;
      r_keep <= '0;
      r_cnt  <= '0;
    end else if (w_in_acc) begin
      r_data <= w_merged;
      r_keep <= RATIO'(keep_mask(32'(r_cnt)));
      r_cnt  <= r_cnt + CLEN'(1);
    end
  end

  // w_done implies w_in_acc, which implies w_ready: the load never overwrites
  // a word the sink has not taken.
  axis_out_reg #(
    .W (OLEN)
  ) u_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (w_done),
    .i_data   ({i_tlast, w_keep_out, w_merged}),
    .i_tready (i_tready),
    .o_tvalid (o_tvalid),
    .o_ready  (w_ready),
    .o_data   (w_out)
  );

  assign {o_tlast, o_tkeep, o_tdata} = w_out;

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Downstream stage of the FIFO. Consumes the FIFO's narrow AXI-Stream read port, DLEN bits per beat.
- Packs RATIO consecutive beats into one wide word of DLEN*RATIO bits for wide consumers such as bus masters and DMA.
- An optional tlast closes a partial word early. A per-lane keep mask marks which lanes hold valid data.
- Full throughput, one input beat per cycle, when the wide sink is always ready.

Parameters:
- DLEN, 8, width of one input beat in bits; matches the FIFO data width.
- RATIO, 4, input beats per output word; integer >= 2.
- CLEN, $clog2(RATIO), derived localparam; lane counter width; not overridable.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rstn  input  1  reset; synchronous, active-low.
- i_tvalid  input  1  narrow beat valid (from FIFO o_rd_tvalid).
- o_tready  output  1  narrow beat ready (to FIFO i_rd_tready).
- i_tdata  input  DLEN  narrow beat data.
- i_tlast  input  1  last beat of packet; tie 0 if unused.
- o_tvalid  output  1  wide word valid.
- i_tready  input  1  wide word ready from sink.
- o_tdata  output  DLEN*RATIO  wide word; lane k is bits [k*DLEN +: DLEN].
- o_tkeep  output  RATIO  lane-valid mask; bit k set means lane k holds data.
- o_tlast  output  1  word closes a packet.

Behaviour:
- Clock and reset: single clock clk. Reset rstn is synchronous, active-low.
- Reset values:
  - o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0.
  - Lane counter = 0; assembly data and keep = 0.
- Reset mid-operation discards any partial word and any held output word, with no flush.
- Internal state:
  - Assembly register: data, keep, lane counter cnt in 0..RATIO-1.
  - Output register: o_tdata, o_tkeep, o_tlast, o_tvalid.
- Handshakes:
  - in_acc = i_tvalid & o_tready.
  - out_acc = o_tvalid & i_tready.
  - o_tready = !o_tvalid | i_tready. This is combinational from i_tready; it must not depend on i_tvalid, i_tdata or i_tlast.
- Per accepted beat:
  - i_tdata is written to assembly lane cnt and keep bit cnt is set.
  - First beat of a word goes to lane 0 (LSBs). Little-endian lane order.
- Word completion when in_acc and (cnt==RATIO-1 or i_tlast):
  - The next cycle loads the output register with the assembly contents merged with the current beat.
  - o_tkeep gets bits 0..cnt set; lanes above cnt are 0 in both o_tdata and o_tkeep.
  - o_tlast = i_tlast; o_tvalid=1.
  - Assembly data, keep and cnt clear to 0.
- Non-completing accepted beat: cnt increments by 1.
- Output register:
  - Holds stable (data, keep, last) while o_tvalid & !i_tready.
  - out_acc without a same-cycle completion clears o_tvalid next cycle; data may stay stale.
  - out_acc with a same-cycle completion reloads the register, and o_tvalid stays 1 (back-to-back words).
- Latency: wide word valid 1 cycle after the completing beat is accepted.
- Boundary conditions:
  - tlast on lane 0 gives a word with o_tkeep=1 and only lane 0 valid.
  - tlast on lane RATIO-1 is a normal full word with o_tlast=1.
  - With the sink stalled, a partial word never advances: o_tready=0, no beat is lost and the assembly register is held.
  - With i_tvalid low, cnt and the assembly register hold; there is no timeout flush.
- Protocol assertions for verification:
  - o_tvalid, once high, stays high until out_acc.
  - o_tkeep is always contiguous from bit 0 and nonzero whenever o_tvalid=1.

Decomposition:
- Shared package axis_pkg holds:
  - function keep_mask(cnt), returning contiguous ones 0..cnt;
  - function clog2-safe counter width helper;
  - the lane-slice convention used by future downsizer and FIFO wrappers.
- No sub-module required. The output register is the only natural split, as axis_out_reg (valid/ready holding register), reusable by a later axis_downsizer.

Test Plan:
- Full words: DLEN=8, RATIO=4, sink ready, feed 0x11,0x22,0x33,0x44,0x55..0x88 back-to-back → o_tdata=0x44332211 then 0x88776655, o_tkeep=4'b1111, o_tlast=0; o_tready stays 1 with no bubbles.
- Early last: feed 0xA1,0xA2 with tlast on 0xA2 → o_tdata=0x0000A2A1, o_tkeep=4'b0011, o_tlast=1; the next beat 0xB1 lands in lane 0 of the following word.
- Single-beat packet: 0xC3 with tlast → o_tdata=0x000000C3, o_tkeep=4'b0001, o_tlast=1.
- Backpressure: i_tready=0 for 10 cycles after the first word completes → o_tvalid stays 1 with data stable; o_tready=0 for the whole stall. After release, the remaining beats assemble correctly with no loss or duplication against a scoreboard.
- Reset mid-word: accept 0x01,0x02, assert rstn=0 for 1 cycle → all outputs 0. Then feed 0x10..0x13 → o_tdata=0x13121110 with no residue of 0x01/0x02.
- Integration and random: FIFO (ALEN=2) feeding the upsizer, random i_tvalid, i_tready and tlast over 10k beats → scoreboard match, with keep-contiguity and valid-stability assertions never firing.
